// File: rtl/mux_n1_flop_rr.sv
// Registered N:1 channel multiplexer with external or round-robin selection,
// a one-cycle valid flag, and per-bit saturating rising-edge counters on data_out.
module mux_n1_flop_rr #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SEL_W     = $clog2(CHANNELS),
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [CHANNELS*WIDTH-1:0]     data_in,
  input  logic [SEL_W-1:0]              selector,
  input  logic                          mode,
  input  logic                          enable,
  input  logic                          clear_count,
  output logic [WIDTH-1:0]              data_out,
  output logic                          valid_out,
  output logic [SEL_W-1:0]              sel_out,
  output logic [WIDTH*CNT_WIDTH-1:0]    rise_count
);

  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [SEL_W-1:0]     rr_q, rr_d;
  logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

  logic [SEL_W-1:0]     chosen;
  logic                 in_range;
  logic [WIDTH-1:0]     chan;

  // Only external selection can point past the last channel; rr_q never does.
  always_comb begin
    chosen   = mode ? rr_q : selector;
    in_range = ({1'b0, chosen} < CH_LIM);
    chan     = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (chosen == SEL_W'(k)) chan = data_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    rr_d    = rr_q;
    if (enable) begin
      data_d  = in_range ? chan : '0;
      sel_d   = chosen;
      valid_d = in_range;
      if (mode) rr_d = (rr_q == LAST_CH) ? '0 : rr_q + SEL_W'(1);
    end
  end

  // A rise is judged at the register output: next value 1 while current value 0.
  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_count)
        cnt_d[i] = '0;
      else if (data_d[i] && !data_q[i] && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      rr_q    <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign sel_out   = sel_q;

  always_comb begin
    rise_count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) rise_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_mux_n1_flop_rr.sv
// Bench for mux_n1_flop_rr: scoreboarded default instance plus directed
// instances for counter saturation and a non-power-of-two channel count.
module tb_mux_n1_flop_rr;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  // Default instance: WIDTH=2, CHANNELS=4, CNT_WIDTH=7
  logic [7:0]  din = '0;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0, en = 1'b0, clr = 1'b0;
  logic [1:0]  d_out, s_out;
  logic        v_out;
  logic [13:0] rise;

  mux_n1_flop_rr u_dut (
    .clk(clk), .reset_L(reset_L), .data_in(din), .selector(sel), .mode(mode),
    .enable(en), .clear_count(clr), .data_out(d_out), .valid_out(v_out),
    .sel_out(s_out), .rise_count(rise)
  );

  // Saturation instance: CNT_WIDTH=3
  logic [7:0] s_din = '0;
  logic [1:0] s_sel = '0;
  logic       s_mode = 1'b0, s_en = 1'b0, s_clr = 1'b0;
  logic [1:0] s_dout, s_sout;
  logic       s_vout;
  logic [5:0] s_rise;

  mux_n1_flop_rr #(.WIDTH(2), .CHANNELS(4), .CNT_WIDTH(3)) u_sat (
    .clk(clk), .reset_L(reset_L), .data_in(s_din), .selector(s_sel), .mode(s_mode),
    .enable(s_en), .clear_count(s_clr), .data_out(s_dout), .valid_out(s_vout),
    .sel_out(s_sout), .rise_count(s_rise)
  );

  // Three-channel instance: selector value 3 is out of range
  logic [5:0]  o_din = 6'b10_01_11;
  logic [1:0]  o_sel = '0;
  logic        o_mode = 1'b0, o_en = 1'b0, o_clr = 1'b0;
  logic [1:0]  o_dout, o_sout;
  logic        o_vout;
  logic [13:0] o_rise;

  mux_n1_flop_rr #(.WIDTH(2), .CHANNELS(3), .CNT_WIDTH(7)) u_odd (
    .clk(clk), .reset_L(reset_L), .data_in(o_din), .selector(o_sel), .mode(o_mode),
    .enable(o_en), .clear_count(o_clr), .data_out(o_dout), .valid_out(o_vout),
    .sel_out(o_sout), .rise_count(o_rise)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  data;
    logic [1:0]  sel;
    logic        valid;
    logic [13:0] rise;
  } exp_t;

  exp_t sb[$];

  logic [1:0] m_data = '0;
  logic [1:0] m_sel  = '0;
  logic       m_valid = 1'b0;
  int         m_rr = 0;
  int         m_cnt [2] = '{0, 0};

  task automatic model_reset();
    m_data = '0; m_sel = '0; m_valid = 1'b0; m_rr = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    sb.delete();
  endtask

  // Predict the default instance from the current inputs, clock once, compare.
  task automatic step();
    exp_t e;
    exp_t g;
    int ch;
    logic [1:0] nd;
    ch = mode ? m_rr : int'(sel);
    nd = m_data;
    if (en) begin
      nd      = din[ch*2 +: 2];
      m_sel   = 2'(ch);
      m_valid = 1'b1;
      if (mode) m_rr = (m_rr + 1) % 4;
    end else begin
      m_valid = 1'b0;
    end
    for (int b = 0; b < 2; b++) begin
      if (clr) m_cnt[b] = 0;
      else if (nd[b] && !m_data[b] && m_cnt[b] < 127) m_cnt[b] = m_cnt[b] + 1;
    end
    m_data  = nd;
    e.data  = m_data;
    e.sel   = m_sel;
    e.valid = m_valid;
    e.rise  = {7'(m_cnt[1]), 7'(m_cnt[0])};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check("sb_data", 32'(d_out), 32'(g.data));
      check("sb_sel", 32'(s_out), 32'(g.sel));
      check("sb_valid", 32'(v_out), 32'(g.valid));
      check("sb_rise", 32'(rise), 32'(g.rise));
    end
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    #2;
    check("rst_data", 32'(d_out), 32'd0);
    check("rst_valid", 32'(v_out), 32'd0);
    check("rst_sel", 32'(s_out), 32'd0);
    check("rst_rise", 32'(rise), 32'd0);
    #1 reset_L = 1'b1;

    // External select sweep
    din = 8'b11_10_01_00; mode = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      step();
      check("sweep_data", 32'(d_out), 32'(k));
      check("sweep_sel", 32'(s_out), 32'(k));
      check("sweep_valid", 32'(v_out), 32'd1);
    end
    check("sweep_cnt", 32'(rise), 32'h082);

    // Asynchronous reset between edges
    reset_L = 1'b0;
    #1;
    check("amid_data", 32'(d_out), 32'd0);
    check("amid_valid", 32'(v_out), 32'd0);
    check("amid_sel", 32'(s_out), 32'd0);
    check("amid_rise", 32'(rise), 32'd0);
    model_reset();
    #1 reset_L = 1'b1;
    sel = 2'd2;
    step();
    check("post_rst_data", 32'(d_out), 32'h2);
    check("post_rst_valid", 32'(v_out), 32'd1);
    check("post_rst_rise", 32'(rise), 32'h080);

    // Round-robin wrap, hold, resume
    mode = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rr_sel", 32'(s_out), 32'(rr_exp[k]));
    end
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      check("hold_valid", 32'(v_out), 32'd0);
      check("hold_sel", 32'(s_out), 32'd1);
      check("hold_data", 32'(d_out), 32'h1);
    end
    en = 1'b1;
    step();
    check("rr_resume", 32'(s_out), 32'd2);
    step();
    step();
    step();
    check("rr_before_switch", 32'(s_out), 32'd1);

    // Mode switch keeps the pointer
    mode = 1'b0; sel = 2'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ext_sel", 32'(s_out), 32'd3);
    end
    mode = 1'b1;
    step();
    check("rr_after_switch", 32'(s_out), 32'd2);

    // Randomised scoreboard traffic
    for (int k = 0; k < 150; k++) begin
      din  = 8'($urandom);
      sel  = 2'($urandom_range(0, 3));
      mode = 1'($urandom_range(0, 1));
      en   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      step();
    end
    en = 1'b0; clr = 1'b0;

    // Saturation and clear priority on a 3-bit counter
    s_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_din = 8'h01; step();
      s_din = 8'h00; step();
    end
    check("sat_cnt", 32'(s_rise[2:0]), 32'd7);
    check("sat_bit1", 32'(s_rise[5:3]), 32'd0);
    s_din = 8'h01; s_clr = 1'b1; step();
    check("clr_on_rise", 32'(s_rise[2:0]), 32'd0);
    s_clr = 1'b0;
    s_din = 8'h00; step();
    s_din = 8'h01; step();
    check("after_clr", 32'(s_rise[2:0]), 32'd1);
    s_en = 1'b0;

    // Out-of-range selector with three channels
    o_en = 1'b1; o_sel = 2'd1;
    step();
    check("odd_in_data", 32'(o_dout), 32'h1);
    check("odd_in_rise", 32'(o_rise), 32'h001);
    o_sel = 2'd3;
    step();
    check("oor_data", 32'(o_dout), 32'd0);
    check("oor_valid", 32'(o_vout), 32'd0);
    check("oor_sel", 32'(o_sout), 32'd3);
    check("oor_rise", 32'(o_rise), 32'h001);
    o_sel = 2'd2;
    step();
    check("odd_ch2_data", 32'(o_dout), 32'h2);
    check("odd_ch2_rise", 32'(o_rise), 32'h081);
    o_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("odd_rr_sel", 32'(o_sout), 32'(k % 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
